// File: rtl/pulse_handshake_s2f_if.sv
// Bundles the slow-side event request signals and the fast-side valid/ready
// channel of pulse_handshake_s2f into one port.
`timescale 1ns/100ps
interface pulse_handshake_s2f_if #(
    parameter int DW    = 8,
    parameter int CNT_W = 8
);
    logic             src_pulse;
    logic [DW-1:0]    src_data;
    logic             src_busy;
    logic [CNT_W-1:0] drop_cnt;
    logic             dst_valid;
    logic [DW-1:0]    dst_data;
    logic             dst_ready;

    modport master (
        output src_pulse, src_data, dst_ready,
        input  src_busy, drop_cnt, dst_valid, dst_data
    );

    modport slave (
        input  src_pulse, src_data, dst_ready,
        output src_busy, drop_cnt, dst_valid, dst_data
    );
endinterface

// File: rtl/pulse_handshake_s2f.sv
// Moves single-cycle payload events from clk_slow to clk_fast using a toggle
// request / toggle acknowledge pair; one event in flight, drops counted.
`timescale 1ns/100ps
module pulse_handshake_s2f #(
    parameter int DW          = 8,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic clk_fast,
    input  logic clk_slow,
    input  logic rst_n,
    pulse_handshake_s2f_if.slave bus
);
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} src_state_t;

    src_state_t       state_reg, state_next;
    logic             req_tgl_reg, req_tgl_next;
    logic [DW-1:0]    hold_reg, hold_next;
    logic [CNT_W-1:0] drop_cnt_reg, drop_cnt_next;

    logic [SYNC_STAGES-1:0] ack_sync_reg, ack_sync_next;
    logic                   ack_hist_reg;
    logic                   ack_change;

    logic [SYNC_STAGES-1:0] req_sync_reg, req_sync_next;
    logic                   req_hist_reg;
    logic                   req_change;

    logic          dst_valid_reg, dst_valid_next;
    logic [DW-1:0] dst_data_reg, dst_data_next;
    logic          ack_tgl_reg, ack_tgl_next;

    // Synchroniser chains: stage 0 samples the foreign toggle, later stages shift.
    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                assign ack_sync_next[gi] = ack_tgl_reg;
                assign req_sync_next[gi] = req_tgl_reg;
            end else begin : g_rest
                assign ack_sync_next[gi] = ack_sync_reg[gi-1];
                assign req_sync_next[gi] = req_sync_reg[gi-1];
            end
        end
    endgenerate

    assign ack_change = ack_sync_reg[SYNC_STAGES-1] ^ ack_hist_reg;
    assign req_change = req_sync_reg[SYNC_STAGES-1] ^ req_hist_reg;

    // ---------------- clk_slow domain ----------------
    always_ff @(posedge clk_slow or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            req_tgl_reg  <= 1'b0;
            hold_reg     <= '0;
            drop_cnt_reg <= '0;
            ack_sync_reg <= '0;
            ack_hist_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            req_tgl_reg  <= req_tgl_next;
            hold_reg     <= hold_next;
            drop_cnt_reg <= drop_cnt_next;
            ack_sync_reg <= ack_sync_next;
            ack_hist_reg <= ack_sync_reg[SYNC_STAGES-1];
        end
    end

    // A pulse on the edge where BUSY releases is still a drop.
    always_comb begin
        state_next    = state_reg;
        req_tgl_next  = req_tgl_reg;
        hold_next     = hold_reg;
        drop_cnt_next = drop_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (bus.src_pulse) begin
                    hold_next    = bus.src_data;
                    req_tgl_next = ~req_tgl_reg;
                    state_next   = BUSY;
                end
            end
            BUSY: begin
                if (bus.src_pulse && (drop_cnt_reg != '1)) begin
                    drop_cnt_next = drop_cnt_reg + 1'b1;
                end
                if (ack_change) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.src_busy = (state_reg == BUSY);
    assign bus.drop_cnt = drop_cnt_reg;

    // ---------------- clk_fast domain ----------------
    always_ff @(posedge clk_fast or negedge rst_n) begin
        if (!rst_n) begin
            req_sync_reg  <= '0;
            req_hist_reg  <= 1'b0;
            dst_valid_reg <= 1'b0;
            dst_data_reg  <= '0;
            ack_tgl_reg   <= 1'b0;
        end else begin
            req_sync_reg  <= req_sync_next;
            req_hist_reg  <= req_sync_reg[SYNC_STAGES-1];
            dst_valid_reg <= dst_valid_next;
            dst_data_reg  <= dst_data_next;
            ack_tgl_reg   <= ack_tgl_next;
        end
    end

    // hold_reg is frozen while the request is in flight, so sampling it here is safe.
    always_comb begin
        dst_valid_next = dst_valid_reg;
        dst_data_next  = dst_data_reg;
        ack_tgl_next   = ack_tgl_reg;
        if (dst_valid_reg && bus.dst_ready) begin
            dst_valid_next = 1'b0;
            ack_tgl_next   = ~ack_tgl_reg;
        end
        if (req_change) begin
            dst_valid_next = 1'b1;
            dst_data_next  = hold_reg;
        end
    end

    assign bus.dst_valid = dst_valid_reg;
    assign bus.dst_data  = dst_data_reg;
endmodule

// File: tb/tb_pulse_handshake_s2f.sv
// Randomised bench for pulse_handshake_s2f: latency-level reference model,
// expected-payload queue, and decoupled monitors on both clock domains.
`timescale 1ns/100ps
module tb_pulse_handshake_s2f;
    localparam int DW          = 8;
    localparam int SYNC_STAGES = 2;
    localparam int CNT_W       = 8;
    localparam int LAT         = SYNC_STAGES + 1;
    localparam int DROP_MAX    = (1 << CNT_W) - 1;

    logic clk_fast = 1'b0;
    logic clk_slow = 1'b0;
    logic rst_n    = 1'b0;
    real  tf_half  = 5.0;
    real  ts_half  = 50.0;

    pulse_handshake_s2f_if #(.DW(DW), .CNT_W(CNT_W)) bus();

    pulse_handshake_s2f #(.DW(DW), .SYNC_STAGES(SYNC_STAGES), .CNT_W(CNT_W)) dut (
        .clk_fast (clk_fast),
        .clk_slow (clk_slow),
        .rst_n    (rst_n),
        .bus      (bus)
    );

    // Integer fast edges vs. x.3 slow edges: the two clocks never share an edge.
    initial forever #(tf_half) clk_fast = ~clk_fast;
    initial begin
        #0.3;
        forever #(ts_half) clk_slow = ~clk_slow;
    end

    int tests = 0;
    int fails = 0;
    int n_acc = 0;
    int n_deliv = 0;
    int ready_mode = 1;

    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] exp_d;

    bit            m_busy, m_valid, m_req_pend, m_ack_pend, s_exit;
    int            m_req_cnt, m_ack_cnt, m_drop;
    logic [DW-1:0] m_hold, m_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_model();
        m_busy = 0; m_valid = 0; m_req_pend = 0; m_ack_pend = 0;
        m_req_cnt = 0; m_ack_cnt = 0; m_drop = 0;
        m_hold = '0; m_data = '0;
        exp_q.delete();
    endtask

    // Reference: valid rises LAT fast edges after acceptance; busy clears LAT
    // slow edges after the consumer handshake; pulses while busy are drops.
    initial forever begin
        @(posedge clk_fast);
        if (rst_n) begin
            if (m_valid && bus.dst_ready) begin
                m_valid = 0; m_ack_pend = 1; m_ack_cnt = 0;
            end
            if (m_req_pend) begin
                m_req_cnt++;
                if (m_req_cnt == LAT) begin
                    m_valid = 1; m_data = m_hold; m_req_pend = 0;
                end
            end
        end
    end

    initial forever begin
        @(posedge clk_slow);
        if (rst_n) begin
            s_exit = 0;
            if (m_ack_pend) begin
                m_ack_cnt++;
                if (m_ack_cnt == LAT) begin
                    s_exit = 1; m_ack_pend = 0;
                end
            end
            if (bus.src_pulse) begin
                if (m_busy) begin
                    if (m_drop != DROP_MAX) m_drop++;
                end else begin
                    m_busy = 1; m_hold = bus.src_data;
                    exp_q.push_back(bus.src_data);
                    m_req_pend = 1; m_req_cnt = 0;
                    n_acc++;
                end
            end
            if (s_exit) m_busy = 0;
        end
    end

    initial forever begin
        @(posedge clk_fast);
        #0.5;
        case (ready_mode)
            0:       bus.dst_ready = 1'b0;
            1:       bus.dst_ready = 1'b1;
            default: bus.dst_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    // Fast-side monitor: timing of dst_valid plus in-order payload scoreboard.
    initial forever begin
        @(negedge clk_fast);
        chk("dst_valid", 32'(bus.dst_valid), 32'(m_valid));
        if (bus.dst_valid) chk("dst_data_held", 32'(bus.dst_data), 32'(m_data));
        if (bus.dst_valid && bus.dst_ready && rst_n) begin
            if (exp_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_event: got data 0x%02h, expected no event at %0t", bus.dst_data, $time);
            end else begin
                exp_d = exp_q.pop_front();
                chk("dst_data", 32'(bus.dst_data), 32'(exp_d));
                n_deliv++;
                $display("[TB] deliver data=0x%02h at %0t", bus.dst_data, $time);
            end
        end
    end

    initial forever begin
        @(negedge clk_slow);
        chk("src_busy", 32'(bus.src_busy), 32'(m_busy));
        chk("drop_cnt", 32'(bus.drop_cnt), 32'(m_drop));
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"},  32'(bus.src_busy),  0);
        chk({tag, "_drop"},  32'(bus.drop_cnt),  0);
        chk({tag, "_valid"}, 32'(bus.dst_valid), 0);
        chk({tag, "_data"},  32'(bus.dst_data),  0);
    endtask

    task automatic do_reset();
        @(posedge clk_fast);
        #1;
        rst_n = 1'b0;
        bus.src_pulse = 1'b0;
        clear_model();
        #1;
        check_reset_outputs("rst");
        repeat (2) @(posedge clk_slow);
        @(posedge clk_fast);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic send(input logic [DW-1:0] d);
        @(negedge clk_slow);
        bus.src_pulse = 1'b1;
        bus.src_data  = d;
        @(negedge clk_slow);
        bus.src_pulse = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((m_busy || m_valid || exp_q.size() != 0) && n < 5000) begin
            @(negedge clk_slow);
            n++;
        end
        if (n >= 5000) begin
            tests++; fails++;
            $display("FAIL %s_timeout: still busy after %0d slow cycles, expected idle", tag, n);
        end
    endtask

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int acc_base, deliv_base, sends;
        bus.src_pulse = 1'b0;
        bus.src_data  = '0;
        bus.dst_ready = 1'b0;
        clear_model();

        // Reset values
        repeat (3) @(posedge clk_slow);
        #1;
        check_reset_outputs("init");
        @(posedge clk_fast);
        #2;
        rst_n = 1'b1;

        // Single event
        ready_mode = 1;
        send(8'hA5);
        wait_idle("single");
        chk("single_drop", 32'(bus.drop_cnt), 0);
        chk("single_count", n_deliv, 1);

        // Backpressure with a drop while held
        ready_mode = 0;
        send(8'h3C);
        n = 0;
        while (!m_valid && n < 500) begin
            @(negedge clk_fast);
            n++;
        end
        chk("bp_valid_seen", 32'(m_valid), 1);
        send(8'h11);
        repeat (50) @(negedge clk_fast);
        chk("bp_valid", 32'(bus.dst_valid), 1);
        chk("bp_data", 32'(bus.dst_data), 32'h3C);
        chk("bp_busy", 32'(bus.src_busy), 1);
        chk("bp_drop", 32'(bus.drop_cnt), 1);
        ready_mode = 1;
        wait_idle("bp");
        chk("bp_count", n_deliv, 2);

        // Saturating drop counter
        ready_mode = 0;
        send(8'h77);
        for (int i = 0; i < 300; i++) send(8'($urandom));
        chk("sat_drop", 32'(bus.drop_cnt), DROP_MAX);
        ready_mode = 1;
        wait_idle("sat");
        chk("sat_count", n_deliv, 3);

        // Pulse on the release edge is dropped, the next one is accepted
        do_reset();
        send(8'h21);
        n = 0;
        while (!(m_ack_pend && m_ack_cnt == LAT - 1) && n < 2000) begin
            @(negedge clk_slow);
            n++;
        end
        chk("b2b_edge_found", 32'(m_ack_cnt), LAT - 1);
        bus.src_pulse = 1'b1;
        bus.src_data  = 8'h99;
        @(negedge clk_slow);
        bus.src_data  = 8'h42;
        @(negedge clk_slow);
        bus.src_pulse = 1'b0;
        chk("b2b_drop", 32'(bus.drop_cnt), 1);
        chk("b2b_busy", 32'(bus.src_busy), 1);
        wait_idle("b2b");
        chk("b2b_count", n_deliv, 5);

        // Reset while the request is still crossing
        @(negedge clk_slow);
        bus.src_pulse = 1'b1;
        bus.src_data  = 8'hE7;
        @(posedge clk_slow);
        #1;
        bus.src_pulse = 1'b0;
        @(posedge clk_fast);
        #1;
        rst_n = 1'b0;
        clear_model();
        #1;
        check_reset_outputs("midrst");
        repeat (2) @(posedge clk_slow);
        @(posedge clk_fast);
        #2;
        rst_n = 1'b1;
        repeat (20) @(negedge clk_slow);
        chk("midrst_no_event", n_deliv, 5);
        send(8'h5A);
        wait_idle("midrst");
        chk("midrst_count", n_deliv, 6);

        // Clock-ratio sweep with random payloads, gaps and backpressure
        for (int r = 0; r < 3; r++) begin
            case (r)
                0:       begin ts_half = 65.0; tf_half = 50.0;  end
                1:       begin ts_half = 70.0; tf_half = 10.0;  end
                default: begin ts_half = 50.0; tf_half = 100.0; end
            endcase
            repeat (4) @(posedge clk_slow);
            do_reset();
            acc_base   = n_acc;
            deliv_base = n_deliv;
            sends      = 0;
            ready_mode = 2;
            for (int i = 0; i < 50; i++) begin
                repeat ($urandom_range(0, 4)) @(negedge clk_slow);
                send(8'($urandom));
                sends++;
            end
            ready_mode = 1;
            wait_idle("sweep");
            chk("sweep_inorder", n_deliv - deliv_base, n_acc - acc_base);
            chk("sweep_drop", 32'(bus.drop_cnt), sends - (n_acc - acc_base));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/pulse_handshake_s2f.md
Name: pulse_handshake_s2f

Overview:
- Carries single-cycle event pulses, each with a DW-bit payload, from the clk_slow domain to the clk_fast domain.
- Uses a toggle request, with a toggle acknowledge returned to clk_slow; this is the slow-to-fast complement of the team's fast-to-slow toggle pulse synchroniser.
- The source side refuses new events until the previous one is acknowledged, and counts events dropped while busy.
- The fast side presents each event as valid/ready with backpressure.

Parameters:
- DW, 8, payload width in bits.
- SYNC_STAGES, 2, flops per synchroniser chain, legal values 2..4.
- CNT_W, 8, width of the saturating drop counter.

Ports:
- clk_fast  in  1  destination clock (primary).
- clk_slow  in  1  source clock, asynchronous to clk_fast.
- rst_n  in  1  reset: asynchronous, active-low, clock clk_fast; applied to both domains (asynchronous assert in both).
- src_pulse  in  1  clk_slow; single-cycle event request.
- src_data  in  DW  clk_slow; payload, sampled with src_pulse.
- src_busy  out  1  clk_slow; high while an event is in flight.
- drop_cnt  out  CNT_W  clk_slow; count of events dropped because src_busy was high.
- dst_valid  out  1  clk_fast; event available.
- dst_data  out  DW  clk_fast; payload, valid while dst_valid is high.
- dst_ready  in  1  clk_fast; consumer accepts.

Behaviour:
- Reset values (all outputs and internal state): src_busy=0, drop_cnt=0, dst_valid=0, dst_data=0; req_tgl=0, ack_tgl=0, all synchroniser flops=0, hold register=0.
- Source FSM (clk_slow), IDLE state:
  - src_pulse=1: capture src_data into hold_reg, invert req_tgl, go to BUSY.
  - src_busy=1 from the next clk_slow edge.
- Source FSM, BUSY state:
  - src_pulse=1 is dropped: hold_reg unchanged, drop_cnt += 1, saturating at all-ones.
  - On detecting a change of synchronised ack_tgl: go to IDLE; src_busy=0 on that same edge.
- Simultaneity (source side):
  - src_pulse on the edge where BUSY exits on ack counts as a drop; it is not accepted.
  - Acceptance is possible only on the next cycle in IDLE.
- Destination (clk_fast):
  - req_tgl passes through SYNC_STAGES flops plus one history flop.
  - A change between the last sync flop and the history flop loads dst_data from hold_reg and sets dst_valid=1.
  - With SYNC_STAGES=2, dst_valid rises on the 3rd clk_fast edge after req_tgl changes (+1 edge metastability tolerance).
- hold_reg timing:
  - hold_reg is stable from acceptance until src_busy falls.
  - It is therefore quasi-static when sampled by clk_fast; no data synchroniser is used.
- Destination handshake:
  - dst_valid holds, and dst_data is stable, until dst_valid && dst_ready on a clk_fast edge.
  - On that edge: dst_valid=0 and ack_tgl is inverted.
  - dst_ready with dst_valid=0 is ignored.
- Ack return (clk_slow):
  - ack_tgl passes through SYNC_STAGES flops plus a history flop; a change releases BUSY.
  - With SYNC_STAGES=2, src_busy falls on the 3rd clk_slow edge after ack_tgl changes.
- Capacity: at most one event is in flight. dst_valid cannot be re-asserted before ack, so no overflow can occur in the fast domain.
- Throughput (for reference): one event per about (SYNC_STAGES+1)·(Tslow+Tfast) plus consumer stall time.
- Reset mid-transfer: every toggle, sync and state flop returns to 0, so the toggle parity is consistent and no spurious event follows deassertion.
- Deassertion: deassert rst_n synchronously per domain externally; the block itself contains no reset synchroniser.
- No ratio limit: the handshake is correct for any clock ratio, including clk_fast slower than clk_slow.

Test Plan:
- Single event: clk_slow=10 MHz, clk_fast=100 MHz; src_pulse with src_data=0xA5, dst_ready=1 → one dst_valid cycle with dst_data=0xA5, 3 clk_fast edges after the req change; src_busy falls 3 clk_slow edges after the ack change; drop_cnt=0.
- Backpressure: dst_ready=0 for 50 fast cycles → dst_valid and dst_data=0x3C held for all 50 cycles; src_busy stays 1 throughout; after dst_ready=1 the event is accepted exactly once and src_busy then falls.
- Drops: second src_pulse (0x11) while busy → drop_cnt=1; first payload delivered, 0x11 never appears at dst. 300 pulses while busy with CNT_W=8 → drop_cnt saturates at 255.
- Back-to-back: src_pulse on the exact edge where src_busy falls → counted as a drop. Pulse on the following edge → accepted and delivered.
- Reset mid-flight: assert rst_n low after the req toggle and before dst_valid → all outputs at reset values. After release, no dst_valid without a new src_pulse; a subsequent event with 0x5A is delivered correctly.
- Ratio sweep: random payloads, clk_fast/clk_slow ratios of 1.3, 7 and 0.5 (fast slower than slow) → scoreboard shows accepted = delivered in order, no duplicates, and drop_cnt equal to the rejected pulse count.
